// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-requester arbiter for a single-port SRAM
//
// Shares one single-port SRAM between a read-only lookup port and a
// read/write config port. Lookup normally wins contested cycles. Config is
// forced through after STARVE_MAX consecutive contested lookup wins.
//
// Ports:
//   clk, rst                       SRAM clock, asynchronous active-high reset
//   lk_req/lk_addr/lk_gnt          lookup read request and combinational grant
//   lk_rvalid/lk_rdata             lookup read return (latency 1, held after)
//   cf_req/cf_wr/cf_addr/cf_wdata  config request and combinational grant (cf_gnt)
//   cf_rvalid/cf_rdata             config read return (reads only, held after)
//   sram_cs/wr/addr/wdata/rdata    SRAM macro interface
//   contention_cnt                 saturating count of cycles with both requests

module sram_port_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 23,
  parameter int STARVE_MAX = 8,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lk_req,
  input  logic [AW-1:0]     lk_addr,
  output logic              lk_gnt,
  output logic              lk_rvalid,
  output logic [DW-1:0]     lk_rdata,
  input  logic              cf_req,
  input  logic              cf_wr,
  input  logic [AW-1:0]     cf_addr,
  input  logic [DW-1:0]     cf_wdata,
  output logic              cf_gnt,
  output logic              cf_rvalid,
  output logic [DW-1:0]     cf_rdata,
  output logic              sram_cs,
  output logic              sram_wr,
  output logic [AW-1:0]     sram_addr,
  output logic [DW-1:0]     sram_wdata,
  input  logic [DW-1:0]     sram_rdata,
  output logic [STAT_W-1:0] contention_cnt
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0]    starve_cnt;
  logic [DW-1:0] lk_hold;
  logic [DW-1:0] cf_hold;
  logic          contested;
  logic          cf_win;

  assign contested = lk_req & cf_req;

  // Config wins when uncontested, or when lookup has used up its allowance.
  assign cf_win = cf_req & (~lk_req | (starve_cnt == STARVE_LIM));

  // Grants are forced low during reset so a read issued in the reset cycle
  // never reaches the SRAM or produces an rvalid.
  assign cf_gnt = ~rst & cf_win;
  assign lk_gnt = ~rst & lk_req & ~cf_win;

  // AND-masking rather than a mux so X on an ungranted port's address or
  // data cannot leak onto the SRAM bus.
  assign sram_cs    = lk_gnt | cf_gnt;
  assign sram_wr    = cf_gnt & cf_wr;
  assign sram_addr  = ({AW{lk_gnt}} & lk_addr) | ({AW{cf_gnt}} & cf_addr);
  assign sram_wdata = {DW{cf_gnt & cf_wr}} & cf_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (~cf_req | cf_gnt) begin
      starve_cnt <= '0;
    end else if (contested & lk_gnt) begin
      // Cannot pass STARVE_LIM: at the limit config wins and clears it.
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_rvalid <= 1'b0;
      cf_rvalid <= 1'b0;
    end else begin
      lk_rvalid <= lk_gnt;
      cf_rvalid <= cf_gnt & ~cf_wr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lk_hold <= '0;
      cf_hold <= '0;
    end else begin
      if (lk_rvalid) lk_hold <= sram_rdata;
      if (cf_rvalid) cf_hold <= sram_rdata;
    end
  end

  // Live SRAM data in the return cycle, last returned value otherwise.
  assign lk_rdata = lk_rvalid ? sram_rdata : lk_hold;
  assign cf_rdata = cf_rvalid ? sram_rdata : cf_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      contention_cnt <= '0;
    end else if (contested & ~(&contention_cnt)) begin
      contention_cnt <= contention_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - scoreboard bench for sram_port_arbiter

module tb_sram_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 23;

  logic          clk;
  logic          rst;
  logic          lk_req;
  logic [AW-1:0] lk_addr;
  logic          lk_gnt;
  logic          lk_rvalid;
  logic [DW-1:0] lk_rdata;
  logic          cf_req;
  logic          cf_wr;
  logic [AW-1:0] cf_addr;
  logic [DW-1:0] cf_wdata;
  logic          cf_gnt;
  logic          cf_rvalid;
  logic [DW-1:0] cf_rdata;
  logic          sram_cs;
  logic          sram_wr;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic [15:0]   contention_cnt;

  logic          s4_lk_gnt, s4_lk_rvalid, s4_cf_gnt, s4_cf_rvalid;
  logic          s4_cs, s4_wr;
  logic [DW-1:0] s4_lk_rdata, s4_cf_rdata, s4_wdata;
  logic [AW-1:0] s4_addr;
  logic [3:0]    s4_cnt;

  sram_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(8), .STAT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .lk_req(lk_req), .lk_addr(lk_addr), .lk_gnt(lk_gnt),
    .lk_rvalid(lk_rvalid), .lk_rdata(lk_rdata),
    .cf_req(cf_req), .cf_wr(cf_wr), .cf_addr(cf_addr), .cf_wdata(cf_wdata),
    .cf_gnt(cf_gnt), .cf_rvalid(cf_rvalid), .cf_rdata(cf_rdata),
    .sram_cs(sram_cs), .sram_wr(sram_wr), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .contention_cnt(contention_cnt)
  );

  // Narrow statistic instance, only its counter is checked.
  sram_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(8), .STAT_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .lk_req(lk_req), .lk_addr(lk_addr), .lk_gnt(s4_lk_gnt),
    .lk_rvalid(s4_lk_rvalid), .lk_rdata(s4_lk_rdata),
    .cf_req(cf_req), .cf_wr(cf_wr), .cf_addr(cf_addr), .cf_wdata(cf_wdata),
    .cf_gnt(s4_cf_gnt), .cf_rvalid(s4_cf_rvalid), .cf_rdata(s4_cf_rdata),
    .sram_cs(s4_cs), .sram_wr(s4_wr), .sram_addr(s4_addr),
    .sram_wdata(s4_wdata), .sram_rdata(sram_rdata),
    .contention_cnt(s4_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM model: synchronous read, one cycle latency.
  logic [DW-1:0] mem [0:65535];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_wr) mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= mem[sram_addr];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] lk_q [$];
  logic [DW-1:0] cf_q [$];
  int            m_starve;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Read-return scoreboard: every rvalid must match the oldest queued read.
  always @(negedge clk) begin
    if (!rst) begin
      if (lk_rvalid) begin
        if (lk_q.size() == 0) check("lk_rvalid_spurious", 1, 0);
        else check("lk_rdata", lk_rdata, lk_q.pop_front());
      end
      if (cf_rvalid) begin
        if (cf_q.size() == 0) check("cf_rvalid_spurious", 1, 0);
        else check("cf_rdata", cf_rdata, cf_q.pop_front());
      end
    end
  end

  // One bus cycle; expected grants come from the bench's own arbitration model.
  task automatic cycle(input logic lr, input logic [AW-1:0] la, input logic cr,
                       input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd);
    logic e_cf, e_lk;
    lk_req = lr; lk_addr = la;
    cf_req = cr; cf_wr = cw; cf_addr = ca; cf_wdata = cd;
    e_cf = cr && (!lr || m_starve == 8);
    e_lk = lr && !e_cf;
    @(negedge clk);
    check("lk_gnt", lk_gnt, e_lk);
    check("cf_gnt", cf_gnt, e_cf);
    check("sram_cs", sram_cs, e_lk | e_cf);
    check("sram_wr", sram_wr, e_cf & cw);
    check("sram_addr", sram_addr, e_lk ? la : (e_cf ? ca : '0));
    if (e_lk) lk_q.push_back(ref_mem[la]);
    if (e_cf && !cw) cf_q.push_back(ref_mem[ca]);
    if (e_cf && cw) ref_mem[ca] = cd;
    if (!cr || e_cf) m_starve = 0;
    else if (lr) m_starve++;
    @(posedge clk);
    #1;
    lk_req = 1'b0; cf_req = 1'b0; cf_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, '0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    lk_req = 1'b0; lk_addr = '0;
    cf_req = 1'b0; cf_wr = 1'b0; cf_addr = '0; cf_wdata = '0;
    @(negedge clk);
    check("rst_sram_cs", sram_cs, 0);
    check("rst_lk_rdata", lk_rdata, 0);
    check("rst_cf_rdata", cf_rdata, 0);
    check("rst_cnt", contention_cnt, 0);
    lk_q.delete();
    cf_q.delete();
    m_starve = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m_starve = 0;
    do_reset();

    // Config write then lookup read of the same word, then hold.
    cycle(0, '0, 1, 1, 16'h1234, 23'h5A5A5A);
    cycle(1, 16'h1234, 0, 0, '0, '0);
    idle(1);
    idle(3);
    check("lk_hold_val", lk_rdata, 23'h5A5A5A);
    check("lk_hold_rvalid", lk_rvalid, 0);
    check("cf_rvalid_after_wr", cf_rvalid, 0);

    // Back-to-back lookups of three freshly written words.
    cycle(0, '0, 1, 1, 16'h0010, 23'h111111);
    cycle(0, '0, 1, 1, 16'h0011, 23'h222222);
    cycle(0, '0, 1, 1, 16'h0012, 23'h333333);
    cycle(0, '0, 1, 1, 16'h0001, 23'h000ABC);
    cycle(1, 16'h0010, 0, 0, '0, '0);
    cycle(1, 16'h0011, 0, 0, '0, '0);
    cycle(1, 16'h0012, 0, 0, '0, '0);
    check("b2b_rvalid_last", lk_rvalid, 1);
    check("b2b_cf_rvalid", cf_rvalid, 0);
    idle(1);

    // Config alone, then a contested cycle that lookup must win.
    cycle(0, '0, 1, 0, 16'h0001, '0);
    cycle(0, '0, 1, 0, 16'h0010, '0);
    cycle(0, '0, 1, 0, 16'h0011, '0);
    cycle(0, '0, 1, 0, 16'h0012, '0);
    cycle(1, 16'h0012, 1, 0, 16'h0001, '0);
    idle(2);

    // Starvation: lookup held, config read raised at cycle 0.
    do_reset();
    for (int k = 0; k <= 9; k++) begin
      cycle(1, 16'h1234, k <= 8, 0, 16'h0001, '0);
      if (k == 8) check("starve_cnt9", contention_cnt, 9);
      if (k == 9) check("starve_lk_back", lk_rvalid, 1);
    end
    idle(2);
    check("lk_q_empty", lk_q.size(), 0);
    check("cf_q_empty", cf_q.size(), 0);

    // Reset asserted in the cycle of a lookup grant.
    lk_req = 1'b1; lk_addr = 16'h0FFF;
    @(negedge clk);
    check("rstg_lk_gnt", lk_gnt, 1);
    rst = 1'b1;
    #1;
    check("rstg_lk_gnt_rst", lk_gnt, 0);
    check("rstg_sram_cs", sram_cs, 0);
    @(posedge clk);
    #1;
    check("rstg_rvalid_in_rst", lk_rvalid, 0);
    lk_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_starve = 0;
    @(negedge clk);
    check("rstg_lk_rvalid", lk_rvalid, 0);
    check("rstg_lk_rdata", lk_rdata, 0);
    check("rstg_cf_rdata", cf_rdata, 0);
    check("rstg_cnt", contention_cnt, 0);
    @(posedge clk);
    #1;

    // Saturation of the narrow counter over 20 contested cycles.
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1, 16'h1234, 1, 1, 16'h0002, 23'(i));
    check("sat_cnt4", s4_cnt, 15);
    check("sat_cnt16", contention_cnt, 20);
    idle(2);
    check("end_lk_q_empty", lk_q.size(), 0);
    check("end_cf_q_empty", cf_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
